// File: rtl/fbrc_seg7_scan.sv
// fbrc_seg7_scan: two-digit multiplexed seven-segment scanner for a 0..15 counter,
// with a 15->0 roll-over pulse and an 8-bit roll-over count.
// Optional macro FBRC_SEG7_LEADING_ZERO_BLANK_EN blanks the tens digit when it is zero.
// All state changes on the falling clock edge; reset is asynchronous, active-high.
module fbrc_seg7_scan #(
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYCLES = 500
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] count,
   output logic [6:0] seg,
   output logic [1:0] dig_sel,
   output logic       wrap_pulse,
   output logic [7:0] wrap_cnt
);

   // Timer must reach the larger of the two slot lengths minus one.
   localparam int TMAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
   localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

   localparam logic [TW-1:0] REF_LAST = TW'(REFRESH_DIV - 1);
   localparam logic [TW-1:0] GAP_LAST = (BLANK_CYCLES > 0) ? TW'(BLANK_CYCLES - 1) : '0;
   localparam bit            HAS_GAP  = (BLANK_CYCLES > 0);

   localparam logic [6:0] SEG_OFF = 7'b1111111;
   localparam logic [1:0] DIG_OFF = 2'b11;
   localparam logic [1:0] DIG_UNITS = 2'b10;
   localparam logic [1:0] DIG_TENS  = 2'b01;

   typedef enum logic [1:0] {
      S_GAP1  = 2'd0,
      S_UNITS = 2'd1,
      S_GAP0  = 2'd2,
      S_TENS  = 2'd3
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [TW-1:0] timer;
   logic [TW-1:0] timer_nxt;
   logic [6:0]    seg_nxt;
   logic [1:0]    dig_sel_nxt;
   logic [3:0]    count_r;

   logic          tens;
   logic [3:0]    units;
   logic [6:0]    units_seg;
   logic [6:0]    tens_seg;

   // Active-low gfedcba pattern for one decimal digit; anything above 9 is dark.
   function automatic logic [6:0] enc(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

   // Split the captured count into two decimal digits; the tens digit is only ever 0 or 1.
   assign tens      = (count_r >= 4'd10);
   assign units     = count_r - (tens ? 4'd10 : 4'd0);
   assign units_seg = enc(units);

`ifdef FBRC_SEG7_LEADING_ZERO_BLANK_EN
   // A leading zero is suppressed so 0..9 show as a single digit.
   assign tens_seg = tens ? enc(4'd1) : SEG_OFF;
`else
   // The tens digit is always drawn, so 7 reads "07".
   assign tens_seg = enc({3'b000, tens});
`endif

   // Scan sequencing: advance on terminal count and compute the pattern for the slot being entered.
   always_comb begin
      state_nxt   = state;
      timer_nxt   = timer + 1'b1;
      seg_nxt     = seg;
      dig_sel_nxt = dig_sel;
      case (state)
         S_UNITS: begin
            if (timer == REF_LAST) begin
               timer_nxt = '0;
               if (HAS_GAP) begin
                  state_nxt   = S_GAP0;
                  seg_nxt     = SEG_OFF;
                  dig_sel_nxt = DIG_OFF;
               end else begin
                  state_nxt   = S_TENS;
                  seg_nxt     = tens_seg;
                  dig_sel_nxt = DIG_TENS;
               end
            end
         end
         S_GAP0: begin
            // With no gap configured this state is left on the very first edge.
            if (!HAS_GAP || timer == GAP_LAST) begin
               timer_nxt   = '0;
               state_nxt   = S_TENS;
               seg_nxt     = tens_seg;
               dig_sel_nxt = DIG_TENS;
            end
         end
         S_TENS: begin
            if (timer == REF_LAST) begin
               timer_nxt = '0;
               if (HAS_GAP) begin
                  state_nxt   = S_GAP1;
                  seg_nxt     = SEG_OFF;
                  dig_sel_nxt = DIG_OFF;
               end else begin
                  state_nxt   = S_UNITS;
                  seg_nxt     = units_seg;
                  dig_sel_nxt = DIG_UNITS;
               end
            end
         end
         default: begin
            // S_GAP1 is also the reset state, so with no gap the first edge enters the units slot.
            if (!HAS_GAP || timer == GAP_LAST) begin
               timer_nxt   = '0;
               state_nxt   = S_UNITS;
               seg_nxt     = units_seg;
               dig_sel_nxt = DIG_UNITS;
            end
         end
      endcase
   end

   // Scan state, slot timer and registered display drive.
   always_ff @(negedge clk or posedge reset) begin
      if (reset) begin
         state   <= S_GAP1;
         timer   <= '0;
         seg     <= SEG_OFF;
         dig_sel <= DIG_OFF;
      end else begin
         state   <= state_nxt;
         timer   <= timer_nxt;
         seg     <= seg_nxt;
         dig_sel <= dig_sel_nxt;
      end
   end

   // Count capture and roll-over detection: only a 15->0 step counts, a held 0 pulses once.
   always_ff @(negedge clk or posedge reset) begin
      if (reset) begin
         count_r    <= 4'd0;
         wrap_pulse <= 1'b0;
         wrap_cnt   <= 8'd0;
      end else begin
         count_r    <= count;
         wrap_pulse <= (count_r == 4'd15) && (count == 4'd0);
         if ((count_r == 4'd15) && (count == 4'd0)) begin
            wrap_cnt <= wrap_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_fbrc_seg7_scan.sv
// Bench for fbrc_seg7_scan: two instances (4/2 and 1/0 slot timing) share clock, reset and count.
// A timeline model derives every output from edges-since-reset and the recorded count history.
module tb_fbrc_seg7_scan;

   logic       clk = 1'b1;
   logic       reset = 1'b1;
   logic [3:0] count = 4'd0;

   logic [6:0] seg_a, seg_b;
   logic [1:0] dig_a, dig_b;
   logic       wp_a, wp_b;
   logic [7:0] wc_a, wc_b;

   int checks = 0;
   int failures = 0;

   // Model state: edges since reset release, count seen at each edge, roll-over model.
   int   edge_n = 0;
   int   hist [0:16383];
   logic m_pulse = 1'b0;
   int   m_cnt = 0;
   bit   model_on = 1'b0;

   fbrc_seg7_scan #(.REFRESH_DIV(4), .BLANK_CYCLES(2)) dut_a (
      .clk(clk), .reset(reset), .count(count),
      .seg(seg_a), .dig_sel(dig_a), .wrap_pulse(wp_a), .wrap_cnt(wc_a));

   fbrc_seg7_scan #(.REFRESH_DIV(1), .BLANK_CYCLES(0)) dut_b (
      .clk(clk), .reset(reset), .count(count),
      .seg(seg_b), .dig_sel(dig_b), .wrap_pulse(wp_b), .wrap_cnt(wc_b));

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [6:0] enc(input int d);
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic logic [6:0] tens_pat(input int t);
`ifdef FBRC_SEG7_LEADING_ZERO_BLANK_EN
      if (t == 0) return 7'b1111111;
`endif
      return enc(t);
   endfunction

   // Timeline: units slot first starts at edge max(B,1); period 2R+2B; value is the count
   // captured on the edge before the slot's entry edge (hist[0] is the reset value 0).
   function automatic void model_disp(input int R, input int B, input int n,
                                      output logic [6:0] s, output logic [1:0] d);
      int off;
      int per;
      int p;
      int e;
      s = 7'b1111111;
      d = 2'b11;
      off = (B == 0) ? 1 : B;
      per = 2 * R + 2 * B;
      if (n < off) return;
      p = (n - off) % per;
      if (p < R) begin
         e = n - p;
         d = 2'b10;
         s = enc(hist[e - 1] % 10);
      end else if (p >= R + B && p < 2 * R + B) begin
         e = n - (p - (R + B));
         d = 2'b01;
         s = tens_pat(hist[e - 1] / 10);
      end
   endfunction

   // Model update on the same edge the DUT uses, reset asynchronously like the DUT.
   always @(negedge clk or posedge reset) begin
      if (reset) begin
         edge_n  = 0;
         hist[0] = 0;
         m_pulse = 1'b0;
         m_cnt   = 0;
      end else begin
         edge_n++;
         hist[edge_n] = int'(count);
         m_pulse = (hist[edge_n - 1] == 15) && (hist[edge_n] == 0);
         if (m_pulse) m_cnt = (m_cnt + 1) % 256;
      end
   end

   // Every-cycle comparison against the model, sampled away from the falling edge.
   always @(posedge clk) begin
      logic [6:0] es;
      logic [1:0] ed;
      if (model_on && !reset) begin
         model_disp(4, 2, edge_n, es, ed);
         check("a_seg", int'(seg_a), int'(es));
         check("a_dig", int'(dig_a), int'(ed));
         model_disp(1, 0, edge_n, es, ed);
         check("b_seg", int'(seg_b), int'(es));
         check("b_dig", int'(dig_b), int'(ed));
         check("a_wrap_pulse", int'(wp_a), int'(m_pulse));
         check("a_wrap_cnt", int'(wc_a), m_cnt);
         check("b_wrap_pulse", int'(wp_b), int'(m_pulse));
         check("b_wrap_cnt", int'(wc_b), m_cnt);
         if (edge_n >= 1) check("b_never_gap", int'(dig_b == 2'b11), 0);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reset mid-slot, verify it acts at once, hold a few cycles, release with a new count.
   task automatic do_reset(input logic [3:0] c);
      reset = 1'b1;
      #1;
      check("rst_seg", int'(seg_a), 7'h7f);
      check("rst_dig", int'(dig_a), 2'b11);
      check("rst_pulse", int'(wp_a), 0);
      check("rst_wcnt", int'(wc_a), 0);
      check("rst_dig_b", int'(dig_b), 2'b11);
      count = c;
      step();
      step();
      reset = 1'b0;
   endtask

   initial begin
      // Power-on reset with count=7, then start running.
      count = 4'd7;
      step();
      step();
      reset = 1'b0;
      model_on = 1'b1;
      repeat (7) step();

      // Reset mid-operation, static 13 pattern: units "3" at edge 2, tens "1" at edge 8.
      do_reset(4'd13);
      step();
      check("s13_pre_units_dig", int'(dig_a), 2'b11);
      step();
      check("s13_units_dig", int'(dig_a), 2'b10);
      check("s13_units_seg", int'(seg_a), 7'b0110000);
      repeat (4) step();
      check("s13_gap0_dig", int'(dig_a), 2'b11);
      repeat (2) step();
      check("s13_tens_seg", int'(seg_a), 7'b1111001);
      repeat (30) step();

      // Mid-slot change 4->5: slot entered at edge 2 holds "4"; next units slot (edge 14) shows "5".
      do_reset(4'd4);
      repeat (3) step();
      count = 4'd5;
      step();
      check("mid_hold_e4", int'(seg_a), 7'b0011001);
      step();
      check("mid_hold_e5", int'(seg_a), 7'b0011001);
      repeat (9) step();
      check("mid_next_units", int'(seg_a), 7'b0010010);

      // Leading zero: count=7 tens slot at edge 8, units slot at edge 14.
      do_reset(4'd7);
      repeat (8) step();
      check("c7_tens_dig", int'(dig_a), 2'b01);
`ifdef FBRC_SEG7_LEADING_ZERO_BLANK_EN
      check("c7_tens_seg", int'(seg_a), 7'b1111111);
`else
      check("c7_tens_seg", int'(seg_a), 7'b1000000);
`endif
      repeat (6) step();
      check("c7_units_seg", int'(seg_a), 7'b1111000);

      // Roll-over: 14,15,0,0,0 gives one pulse; 5->0 gives none; 256 roll-overs return to 0.
      do_reset(4'd14);
      step();
      count = 4'd15;
      step();
      count = 4'd0;
      step();
      check("roll_pulse", int'(wp_a), 1);
      check("roll_cnt1", int'(wc_a), 1);
      step();
      check("roll_pulse_end", int'(wp_a), 0);
      step();
      check("roll_held0", int'(wp_a), 0);
      count = 4'd5;
      step();
      count = 4'd0;
      step();
      check("no_pulse_5to0", int'(wp_a), 0);
      check("no_pulse_cnt", int'(wc_a), 1);
      for (int i = 0; i < 255; i++) begin
         count = 4'd15;
         step();
         count = 4'd0;
         step();
      end
      check("roll_256_cnt", int'(wc_a), 0);
      check("roll_256_cnt_b", int'(wc_b), 0);

      // Randomized traffic: mostly counter-like increments, sometimes jumps and holds.
      for (int i = 0; i < 3000; i++) begin
         int r;
         r = int'($urandom_range(0, 99));
         if (r < 60) count = count + 4'd1;
         else if (r < 80) count = 4'($urandom_range(0, 15));
         else if (r < 90) count = 4'd0;
         if (i == 1500) do_reset(4'($urandom_range(0, 15)));
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
